// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================
// Package : gpu_pkg
// Shared fetch-FSM state encoding and default widths.
// Rev     : 1.0
// ============================================================
package gpu_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCHING = 2'd1,
    RELEASE  = 2'd2,
    DONE     = 2'd3
  } fetch_state_t;

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================
// Module : icache_array
// Direct-mapped tag/data/valid storage with combinational lookup.
// Rev    : 1.0
// ============================================================
module icache_array
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int CACHE_LINES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  localparam int INDEX_BITS = index_bits(CACHE_LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [DATA_BITS-1:0]   r_data [CACHE_LINES];
  logic [TAG_BITS-1:0]    r_tag  [CACHE_LINES];
  logic [CACHE_LINES-1:0] r_valid;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [TAG_BITS-1:0]   w_wr_tag;

  assign w_lk_idx = lookup_addr[INDEX_BITS-1:0];
  assign w_lk_tag = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign w_wr_idx = wr_addr[INDEX_BITS-1:0];
  assign w_wr_tag = wr_addr[ADDR_BITS-1:INDEX_BITS];

  assign hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign hit_data = r_data[w_lk_idx];

  // Flush wins over a same-cycle fill so the entry stays invalid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[w_wr_idx] <= wr_data;
      r_tag[w_wr_idx]  <= w_wr_tag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_cache.sv
`default_nettype none
// ============================================================
// Module : instr_fetch_cache
// Instruction fetch FSM with one outstanding miss over a direct-mapped cache.
// Rev    : 1.0
// ============================================================
module instr_fetch_cache
  import gpu_pkg::*;
#(
  parameter int          ADDR_BITS        = DEFAULT_ADDR_BITS,
  parameter int          DATA_BITS        = DEFAULT_DATA_BITS,
  parameter int          CACHE_LINES      = 4,
  parameter logic [15:0] MISS_COUNT_RESET = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [ADDR_BITS-1:0] pc,
  input  logic                 flush,
  output logic                 instr_valid,
  output logic [DATA_BITS-1:0] instruction,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic [15:0]          miss_count
);

  fetch_state_t r_state;
  logic         r_fill_squash;

  logic                 w_hit;
  logic [DATA_BITS-1:0] w_hit_data;
  logic                 w_fill_en;

  // mem_read_address holds the accepted pc for the whole miss, so it doubles as the fill address.
  assign w_fill_en = (r_state == FETCHING) && mem_read_ready && !flush && !r_fill_squash;

  icache_array #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_BITS  (DATA_BITS),
    .CACHE_LINES(CACHE_LINES)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .lookup_addr(pc),
    .hit        (w_hit),
    .hit_data   (w_hit_data),
    .wr_en      (w_fill_en),
    .wr_addr    (mem_read_address),
    .wr_data    (mem_read_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_fill_squash    <= 1'b0;
      instr_valid      <= 1'b0;
      instruction      <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      miss_count       <= MISS_COUNT_RESET;
    end else begin
      case (r_state)
        IDLE: begin
          if (fetch_req) begin
            if (w_hit && !flush) begin
              instruction <= w_hit_data;
              instr_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= pc;
              r_fill_squash    <= 1'b0;
              if (miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
              end
              r_state <= FETCHING;
            end
          end
        end
        FETCHING: begin
          // A flush seen while the miss is in flight must keep the late fill out of the cache.
          if (flush) begin
            r_fill_squash <= 1'b1;
          end
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            instruction    <= mem_read_data;
            r_state        <= RELEASE;
          end
        end
        RELEASE: begin
          if (!mem_read_ready) begin
            instr_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (!fetch_req) begin
            instr_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_cache.sv
`default_nettype none
// ============================================================
// Module : tb_instr_fetch_cache
// Table-driven bench for instr_fetch_cache with a responding memory controller.
// Rev    : 1.0
// ============================================================
module tb_instr_fetch_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  pc;
  logic        flush;
  logic        instr_valid;
  logic [15:0] instruction;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [15:0] miss_count;

  logic        sat_instr_valid;
  logic [15:0] sat_instruction;
  logic        sat_mem_read_valid;
  logic [7:0]  sat_mem_read_address;
  logic [15:0] sat_miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_cache #(.ADDR_BITS(8), .DATA_BITS(16), .CACHE_LINES(4)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .instr_valid(instr_valid), .instruction(instruction),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .miss_count(miss_count)
  );

  // Same stimulus, counter starting near saturation.
  instr_fetch_cache #(.ADDR_BITS(8), .DATA_BITS(16), .CACHE_LINES(4),
                      .MISS_COUNT_RESET(16'hFFFE)) dut_sat (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .instr_valid(sat_instr_valid), .instruction(sat_instruction),
    .mem_read_valid(sat_mem_read_valid), .mem_read_address(sat_mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .miss_count(sat_miss_count)
  );

  typedef struct {
    bit          pre_flush;
    logic [7:0]  addr;
    logic [15:0] word;
    int          lat;
    int          hold;
    int          flush_at;
    int          drop_at;
    bit          exp_hit;
    int          exp_cycles;
    logic [15:0] exp_instr;
    logic [15:0] exp_miss;
  } vec_t;

  vec_t vecs[20];
  vec_t v_after_reset;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_fetch(input vec_t v, input int idx);
    int          cyc;
    int          cnt;
    int          hcnt;
    bit          done;
    bit          gave;
    bit          saw_mem;
    bit          bad_rel;
    logic [7:0]  addr_seen;
    logic [15:0] got;
    logic [16:0] sat_sum;
    cyc = 0; cnt = 0; hcnt = 0;
    done = 0; gave = 0; saw_mem = 0; bad_rel = 0;
    addr_seen = 8'h00; got = 16'h0000;
    if (v.pre_flush) begin
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
    end
    @(negedge clk);
    pc        = v.addr;
    fetch_req = 1'b1;
    flush     = (v.flush_at == 0);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (mem_read_valid) begin
        saw_mem   = 1;
        addr_seen = mem_read_address;
        if (gave) bad_rel = 1;
      end
      if (mem_read_ready && !mem_read_valid) begin
        if (hcnt >= v.hold) mem_read_ready = 1'b0;
        else hcnt++;
      end else if (mem_read_valid && !mem_read_ready && !gave) begin
        cnt++;
        if (cnt >= v.lat) begin
          mem_read_ready = 1'b1;
          mem_read_data  = v.word;
          gave           = 1;
        end
      end
      if (instr_valid) begin
        done = 1;
        got  = instruction;
      end
      if (cyc == v.flush_at) flush = 1'b1;
      if (cyc >= v.drop_at) fetch_req = 1'b0;
    end
    check($sformatf("v%0d done_in_time", idx), {31'd0, done}, 32'd1);
    check($sformatf("v%0d latency", idx), cyc, v.exp_cycles);
    check($sformatf("v%0d instruction", idx), {16'd0, got}, {16'd0, v.exp_instr});
    check($sformatf("v%0d mem_request_seen", idx), {31'd0, saw_mem}, {31'd0, !v.exp_hit});
    if (!v.exp_hit)
      check($sformatf("v%0d mem_read_address", idx), {24'd0, addr_seen}, {24'd0, v.addr});
    check($sformatf("v%0d request_in_release", idx), {31'd0, bad_rel}, 32'd0);
    check($sformatf("v%0d miss_count", idx), {16'd0, miss_count}, {16'd0, v.exp_miss});
    sat_sum = 17'h0FFFE + {1'b0, v.exp_miss};
    check($sformatf("v%0d sat_miss_count", idx), {16'd0, sat_miss_count},
          (sat_sum > 17'h0FFFF) ? 32'h0000FFFF : {15'd0, sat_sum});
    fetch_req = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d instr_valid_drop", idx), {31'd0, instr_valid}, 32'd0);
    check($sformatf("v%0d idle_no_request", idx), {31'd0, mem_read_valid}, 32'd0);
  endtask

  initial begin
    //          pre  addr   word      lat hold fl  drop  hit cyc instr     miss
    vecs[0]  = '{0, 8'h05, 16'hA5A5, 2, 0, -1, 1000, 0, 4, 16'hA5A5, 16'd1};
    vecs[1]  = '{0, 8'h05, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'hA5A5, 16'd1};
    vecs[2]  = '{0, 8'h01, 16'h1111, 1, 0, -1, 1000, 0, 3, 16'h1111, 16'd2};
    vecs[3]  = '{0, 8'h05, 16'h5555, 2, 0, -1, 1000, 0, 4, 16'h5555, 16'd3};
    vecs[4]  = '{0, 8'h01, 16'h1112, 3, 0, -1, 1000, 0, 5, 16'h1112, 16'd4};
    vecs[5]  = '{0, 8'h01, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'h1112, 16'd4};
    vecs[6]  = '{0, 8'h02, 16'h2222, 2, 0, -1, 1000, 0, 4, 16'h2222, 16'd5};
    vecs[7]  = '{0, 8'h02, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'h2222, 16'd5};
    vecs[8]  = '{1, 8'h02, 16'h2233, 2, 0, -1, 1000, 0, 4, 16'h2233, 16'd6};
    vecs[9]  = '{0, 8'h02, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'h2233, 16'd6};
    vecs[10] = '{0, 8'h03, 16'h3333, 3, 0,  2, 1000, 0, 5, 16'h3333, 16'd7};
    vecs[11] = '{0, 8'h03, 16'h3334, 2, 0, -1, 1000, 0, 4, 16'h3334, 16'd8};
    vecs[12] = '{0, 8'h03, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'h3334, 16'd8};
    vecs[13] = '{0, 8'h03, 16'h3335, 2, 0,  0, 1000, 0, 4, 16'h3335, 16'd9};
    vecs[14] = '{0, 8'h03, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'h3335, 16'd9};
    vecs[15] = '{0, 8'h00, 16'h0A0A, 2, 3, -1, 1000, 0, 7, 16'h0A0A, 16'd10};
    vecs[16] = '{0, 8'h04, 16'h4444, 2, 0,  2, 1000, 0, 4, 16'h4444, 16'd11};
    vecs[17] = '{0, 8'h04, 16'h4445, 2, 0, -1, 1000, 0, 4, 16'h4445, 16'd12};
    vecs[18] = '{0, 8'h06, 16'h6666, 2, 0, -1,    1, 0, 4, 16'h6666, 16'd13};
    vecs[19] = '{0, 8'h06, 16'h0000, 2, 0, -1, 1000, 1, 1, 16'h6666, 16'd13};
    v_after_reset = '{0, 8'h06, 16'h6677, 2, 0, -1, 1000, 0, 4, 16'h6677, 16'd1};

    reset = 1'b1; fetch_req = 1'b0; pc = 8'h00; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    check("reset instruction", {16'd0, instruction}, 32'd0);
    check("reset mem_read_valid", {31'd0, mem_read_valid}, 32'd0);
    check("reset mem_read_address", {24'd0, mem_read_address}, 32'd0);
    check("reset miss_count", {16'd0, miss_count}, 32'd0);
    check("reset sat_miss_count", {16'd0, sat_miss_count}, 32'h0000FFFE);

    for (int i = 0; i < 20; i++) begin
      run_fetch(vecs[i], i);
    end

    // Reset while a miss is outstanding.
    @(negedge clk);
    pc = 8'h07; fetch_req = 1'b1;
    @(negedge clk);
    check("midreset request_issued", {31'd0, mem_read_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset mem_read_valid", {31'd0, mem_read_valid}, 32'd0);
    check("midreset miss_count", {16'd0, miss_count}, 32'd0);
    check("midreset instr_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    run_fetch(v_after_reset, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_cache.md
INSTR_FETCH_CACHE -- requirements
Module: instr_fetch_cache

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, program-memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, instruction width.
REQ-003 SHALL have parameter CACHE_LINES, default 4, direct-mapped entries, power of two, >=2.
REQ-004 SHALL have port clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fetch_req  input  1  core requests instruction at pc; held high until instr_valid.
REQ-006 SHALL have port pc  input  ADDR_BITS  fetch address.
REQ-007 SHALL have port flush  input  1  invalidate all cache entries.
REQ-008 SHALL have port instr_valid  output  1  instruction holds requested word.
REQ-009 SHALL have port instruction  output  DATA_BITS  fetched word.
REQ-010 SHALL have port mem_read_valid  output  1  read request to program-memory controller.
REQ-011 SHALL have port mem_read_address  output  ADDR_BITS  request address.
REQ-012 SHALL have port mem_read_ready  input  1  controller response strobe; stays high until mem_read_valid drops.
REQ-013 SHALL have port mem_read_data  input  DATA_BITS  response word, valid while mem_read_ready.
REQ-014 SHALL have port miss_count  output  16  saturating miss counter.

Function
REQ-015 SHALL implement states IDLE, FETCHING, RELEASE, DONE.
REQ-016 Index = pc[log2(CACHE_LINES)-1:0]; tag = remaining upper pc bits; hit = entry valid and tag equal.
REQ-017 IDLE, fetch_req=1, hit: instruction <= entry data, instr_valid <= 1, -> DONE (1-cycle hit latency).
REQ-018 IDLE, fetch_req=1, miss: mem_read_valid <= 1, mem_read_address <= pc, miss_count += 1 unless 16'hFFFF, -> FETCHING.
REQ-019 pc SHALL be sampled only at the IDLE accept edge; later pc changes ignored until return to IDLE.
REQ-020 FETCHING, mem_read_ready=1: mem_read_valid <= 0, instruction <= mem_read_data, write data/tag/valid to indexed entry, -> RELEASE; else hold request stable.
REQ-021 RELEASE: wait for mem_read_ready=0, then instr_valid <= 1, -> DONE; no new request issued while mem_read_ready=1.
REQ-022 DONE: instr_valid and instruction held; fetch_req=0 -> instr_valid <= 0, -> IDLE.
REQ-023 Miss-to-instr_valid latency = memory latency + controller release cycle + 1; minimum 3 cycles after accept.
REQ-024 flush=1 any cycle SHALL clear all valid bits at that edge.
REQ-025 flush and fetch_req same cycle in IDLE: treated as miss.
REQ-026 flush during FETCHING or same cycle as the fill: word still delivered to core but not written to cache (entry remains invalid).
REQ-027 fetch_req dropped before instr_valid: outstanding memory handshake completes normally; instr_valid asserted for one cycle in DONE then -> IDLE.
REQ-028 At most one outstanding memory request at any time.

Reset
REQ-029 reset SHALL set state IDLE, instr_valid 0, instruction 0, mem_read_valid 0, mem_read_address 0, miss_count 0, all valid bits 0; data/tag arrays need no reset.
REQ-030 reset mid-FETCHING SHALL drop mem_read_valid at that edge; the controller is reset by the same system reset.

Structure
REQ-031 State encoding and default ADDR_BITS/DATA_BITS constants SHALL live in shared package gpu_pkg.
REQ-032 Storage (data, tag, valid arrays, lookup, write port, flush clear) SHALL be sub-module icache_array; FSM and counter in instr_fetch_cache.

Verification
REQ-033 Cold miss: reset, pc=8'h05, fetch_req; memory returns 16'hA5A5 after 2 cycles -> mem_read_address=8'h05, instruction=16'hA5A5, miss_count=1.
REQ-034 Hit: repeat pc=8'h05 -> instr_valid 1 cycle after request, no mem_read_valid, miss_count stays 1.
REQ-035 Conflict: pc=8'h01 then 8'h05 then 8'h01 (CACHE_LINES=4) -> three misses, miss_count=3.
REQ-036 Flush: fill pc=8'h02, pulse flush, refetch 8'h02 -> miss issued; flush during FETCHING -> data delivered, next fetch misses.
REQ-037 Release: hold mem_read_ready high 3 cycles after valid drop -> instr_valid waits; no new mem_read_valid in RELEASE.
REQ-038 Saturation: preload miss_count 16'hFFFE, two misses -> 16'hFFFF held.
